// File: rtl/divider_seq_if.sv
// Request/response bundle between the M-extension control and the
// sequential divider.
`ifndef DIV_OP_WIDTH
`define DIV_OP_WIDTH 2
`endif

interface divider_seq_if #(
  parameter int XLEN = 32
);
  logic                     div_valid;
  logic [`DIV_OP_WIDTH-1:0] DIVop;
  logic [XLEN-1:0]          rs1;
  logic [XLEN-1:0]          rs2;
  logic [XLEN-1:0]          div_rslt;
  logic                     div_ready;
  logic                     busy;

  modport master (
    output div_valid, DIVop, rs1, rs2,
    input  div_rslt, div_ready, busy
  );

  modport slave (
    input  div_valid, DIVop, rs1, rs2,
    output div_rslt, div_ready, busy
  );
endinterface

// File: rtl/divider_seq.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle, 34-cycle request-to-result latency.
module divider_seq #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         resetn,
  divider_seq_if.slave dif
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [1:0]      op;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] rem;
  logic [4:0]      cnt;
  logic            q_neg;
  logic            r_neg;
  logic [XLEN-1:0] rslt;

  logic            sgn_op;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN:0]   rem_sh;
  logic            fits;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] rslt_nxt;

  // DIV and REM are the even opcodes
  assign sgn_op = ~dif.DIVop[0];

  always_comb begin
    a_mag = dif.rs1;
    b_mag = dif.rs2;
    if (sgn_op && dif.rs1[XLEN-1]) a_mag = -dif.rs1;
    if (sgn_op && dif.rs2[XLEN-1]) b_mag = -dif.rs2;
  end

  always_comb begin
    rem_sh  = {rem, quo[XLEN-1]};
    fits    = rem_sh >= {1'b0, dvs};
    rem_nxt = rem_sh[XLEN-1:0];
    if (fits) rem_nxt = XLEN'(rem_sh - {1'b0, dvs});
    quo_nxt = {quo[XLEN-2:0], fits};
    q_fix   = quo_nxt;
    r_fix   = rem_nxt;
    if (q_neg && dvs != '0) q_fix = -quo_nxt;
    if (r_neg) r_fix = -rem_nxt;
    rslt_nxt = op[1] ? r_fix : q_fix;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (dif.div_valid) state_nxt = CALC;
      CALC: if (cnt == 5'd0)   state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dif.div_ready = 1'b0;
    dif.busy      = 1'b0;
    unique case (state)
      IDLE: ;
      CALC: dif.busy = 1'b1;
      DONE: begin
        dif.busy      = 1'b1;
        dif.div_ready = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op    <= '0;
      quo   <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      rslt  <= '0;
    end else begin
      unique case (state)
        IDLE: if (dif.div_valid) begin
          op    <= dif.DIVop;
          quo   <= a_mag;
          dvs   <= b_mag;
          rem   <= '0;
          cnt   <= 5'd31;
          q_neg <= sgn_op & (dif.rs1[XLEN-1] ^ dif.rs2[XLEN-1]);
          r_neg <= sgn_op & dif.rs1[XLEN-1];
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) rslt <= rslt_nxt;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  assign dif.div_rslt = rslt;

endmodule

// File: tb/tb_divider_seq.sv
// Directed and reference-model checks for divider_seq.
// Drives on the falling edge, samples on the falling edge.
module tb_divider_seq;

  logic clk;
  logic resetn;
  int   errs;
  int   checks;

  divider_seq_if dif ();

  divider_seq dut (
    .clk    (clk),
    .resetn (resetn),
    .dif    (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'd0: return ovf ? a : 32'($signed(a) / $signed(b));
      2'd1: return a / b;
      2'd2: return ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  task automatic run(input logic [1:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] exp,
                     input bit scr,
                     input bit timing,
                     input string tag);
    int cyc;
    int bcnt;
    @(negedge clk);
    dif.div_valid = 1'b1;
    dif.DIVop     = op;
    dif.rs1       = a;
    dif.rs2       = b;
    cyc  = 1;
    bcnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (dif.busy) bcnt++;
      if (scr && cyc == 2) begin
        dif.DIVop = ~op;
        dif.rs1   = ~a;
        dif.rs2   = b + 32'd3;
      end
    end while (!dif.div_ready && cyc < 100);
    dif.div_valid = 1'b0;
    chk({tag, "_rslt"}, dif.div_rslt, exp);
    if (timing) begin
      chk({tag, "_lat"}, 32'(cyc), 32'd34);
      chk({tag, "_busy"}, 32'(bcnt), 32'd33);
    end
    @(negedge clk);
    chk({tag, "_pulse"}, {30'd0, dif.div_ready, dif.busy}, 32'd0);
    if (timing) chk({tag, "_hold"}, dif.div_rslt, exp);
  endtask

  initial begin
    logic [31:0] edge_v [6];
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    bit          seen;
    errs   = 0;
    checks = 0;
    dif.div_valid = 1'b0;
    dif.DIVop     = 2'd0;
    dif.rs1       = '0;
    dif.rs2       = '0;
    resetn = 1'b1;
    #3 resetn = 1'b0;
    #10;
    chk("reset", {dif.div_rslt[29:0], dif.div_ready, dif.busy}, 32'd0);
    chk("reset_rslt", dif.div_rslt, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    run(2'd1, 32'd100, 32'd7, 32'd14, 0, 1, "divu_100_7");
    run(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 1, "rem_m7_2");
    run(2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 1, "div_m7_2");
    run(2'd3, 32'hFFFF_FFF9, 32'd2, 32'd1, 0, 1, "remu_m7_2");
    run(2'd0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 0, 1, "div_z");
    run(2'd1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 0, 1, "divu_z");
    run(2'd2, 32'h1234_5678, 32'd0, 32'h1234_5678, 0, 1, "rem_z");
    run(2'd3, 32'h1234_5678, 32'd0, 32'h1234_5678, 0, 1, "remu_z");
    run(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1, "div_ovf");
    run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1, "rem_ovf");
    run(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1, "divu_ovf");
    run(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1, "remu_ovf");
    run(2'd0, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 0, 1, "div_100_m7");
    run(2'd1, 32'd1000, 32'd3, 32'd333, 1, 1, "scramble");

    // abort in the middle of CALC
    @(negedge clk);
    dif.div_valid = 1'b1;
    dif.DIVop     = 2'd1;
    dif.rs1       = 32'd1000;
    dif.rs2       = 32'd3;
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    dif.div_valid = 1'b0;
    #1;
    chk("abort_rslt", dif.div_rslt, 32'd0);
    chk("abort_ctl", {30'd0, dif.div_ready, dif.busy}, 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (dif.div_ready || dif.busy) seen = 1'b1;
    end
    chk("abort_quiet", {31'd0, seen}, 32'd0);
    run(2'd2, 32'd1000, 32'd7, 32'd6, 0, 1, "after_abort");

    edge_v[0] = 32'd0;
    edge_v[1] = 32'd1;
    edge_v[2] = 32'hFFFF_FFFF;
    edge_v[3] = 32'h7FFF_FFFF;
    edge_v[4] = 32'h8000_0000;
    for (int i = 0; i < 400; i++) begin
      edge_v[5] = $urandom;
      a  = (i % 2 == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
      b  = edge_v[$urandom_range(0, 5)];
      if (i % 3 == 0) b = $urandom_range(1, 300);
      op = 2'($urandom_range(0, 3));
      run(op, a, b, ref_div(op, a, b), 0, 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
